ps2_key_decoder: RTL

Upstream input stage of the maze game: receives raw PS/2 keyboard frames on `ps2_clk`/`ps2_data`, validates them, tracks the set-2 prefix bytes (0xE0 extended, 0xF0 break), and emits single-cycle key-press pulses on `up`, `down`, `left`, `right` and `enter`. Those pulses feed the level selector, the move controller and the game FSM. Typematic auto-repeat is suppressed, so one physical press produces exactly one pulse.

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_frame_rx.sv | 119 +++++++++++
 rtl/ps2_key_decoder.sv | 95 +++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: set-2 scan codes, key indices
// into the held mask, and the scan-code to key lookup.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam int unsigned NUM_KEYS  = 5;
    localparam int unsigned KEY_UP    = 0;
    localparam int unsigned KEY_DOWN  = 1;
    localparam int unsigned KEY_LEFT  = 2;
    localparam int unsigned KEY_RIGHT = 3;
    localparam int unsigned KEY_ENTER = 4;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_hit_t;

    // Arrows exist only as extended codes; Enter only as the plain code
    // (E0 5A is keypad Enter and is deliberately not mapped).
    function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
        key_hit_t r;
        r.hit = 1'b0;
        r.idx = 3'd0;
        if (ext) begin
            case (code)
                SC_UP:    begin r.hit = 1'b1; r.idx = 3'(KEY_UP);    end
                SC_DOWN:  begin r.hit = 1'b1; r.idx = 3'(KEY_DOWN);  end
                SC_LEFT:  begin r.hit = 1'b1; r.idx = 3'(KEY_LEFT);  end
                SC_RIGHT: begin r.hit = 1'b1; r.idx = 3'(KEY_RIGHT); end
                default:  ;
            endcase
        end else if (code == SC_ENTER) begin
            r.hit = 1'b1;
            r.idx = 3'(KEY_ENTER);
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw bus, samples 11-bit frames on falling
// ps2_clk edges, checks start/parity/stop and abandons stalled partial frames.
module ps2_frame_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       rst_sys,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);
    import ps2_pkg::*;

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fall;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    // Two-flop synchronisers plus the edge register; idle bus is high.
    always_ff @(posedge clk) begin
        if (rst_sys) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    // Bit sequencing, frame check and timeout; an edge always beats a timeout.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = tmo_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (fall) begin
            tmo_d = '0;
            if (bit_cnt_q == 4'd0) begin
                // A high start bit is dropped so the next edge can realign.
                if (!dat_s2_q) begin
                    bit_cnt_d = 4'd1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d   = {dat_s2_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
                parity_d  = dat_s2_q;
                bit_cnt_d = 4'd10;
            end else begin
                bit_cnt_d = 4'd0;
                if ((^{shift_q, parity_q}) && dat_s2_q) begin
                    byte_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_d     = '0;
                bit_cnt_d = 4'd0;
                err_d     = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst_sys) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            byte_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_q     <= tmo_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = valid_q;
    assign err        = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Maze-game keyboard front end: turns received set-2 bytes into single-cycle press
// pulses, tracking E0/F0 prefixes and suppressing typematic repeats.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       rst_sys,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       enter,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);
    import ps2_pkg::*;

    logic [7:0]          rx_byte;
    logic                byte_valid;
    logic                rx_err;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press;
    key_hit_t            hit;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_sys   (rst_sys),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .err       (rx_err)
    );

    assign hit = key_lookup(rx_byte, ext_q);

    // Prefix tracking, held mask and press pulses; pulses ride on byte_valid.
    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        held_d = held_q;
        press  = '0;
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (hit.hit) begin
                    if (brk_q) begin
                        held_d[hit.idx] = 1'b0;
                    end else if (!held_q[hit.idx]) begin
                        press[hit.idx]  = 1'b1;
                        held_d[hit.idx] = 1'b1;
                    end
                end
            end
        end
    end

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (rst_sys) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            held_q <= '0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            held_q <= held_d;
        end
    end

    assign up         = press[KEY_UP];
    assign down       = press[KEY_DOWN];
    assign left       = press[KEY_LEFT];
    assign right      = press[KEY_RIGHT];
    assign enter      = press[KEY_ENTER];
    assign scan_code  = rx_byte;
    assign scan_valid = byte_valid;
    assign frame_err  = rx_err;

endmodule
